// File: rtl/idct_pkg.sv
// Shared definitions for the 1-D IDCT stages and the transpose buffer between them.
// Elements are sign-magnitude: bit W-1 is the sign, the rest is the magnitude.
package idct_pkg;

    localparam int unsigned IDCT_W  = 17;
    localparam int unsigned IDCT_N  = 8;
    localparam int unsigned IDCT_CW = 3;

    localparam logic [IDCT_CW-1:0] IDCT_LAST = 3'(IDCT_N - 1);

    typedef logic [IDCT_W-1:0] sm_t;

    // Negative zero has two encodings; collapse it to +0 so downstream compares are simple.
    function automatic sm_t sm_norm(input sm_t x);
        sm_t r;
        r = x;
        if (x == {1'b1, {(IDCT_W-1){1'b0}}}) begin
            r = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/idct_tb_bank.sv
// One 8x8 element bank of the transpose buffer: row-wide write port, combinational
// column-wide read port. Storage is deliberately not reset.
module idct_tb_bank
    import idct_pkg::*;
(
    input  logic                     clk,
    input  logic                     we,
    input  logic [IDCT_CW-1:0]       row,
    input  logic [IDCT_N*IDCT_W-1:0] wdata,
    input  logic [IDCT_CW-1:0]       col,
    output logic [IDCT_N*IDCT_W-1:0] rdata
);

    sm_t mem [IDCT_N][IDCT_N];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < IDCT_N; k++) begin
                mem[row][k] <= wdata[k*IDCT_W +: IDCT_W];
            end
        end
    end

    // Lane k of the read vector is row k of the selected column.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < IDCT_N; k++) begin
            rdata[k*IDCT_W +: IDCT_W] = mem[k][col];
        end
    end

endmodule

// File: rtl/idct_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer: rows in from the row pass, columns out to the column pass.
// One bank fills while the other drains, so a vector per cycle is sustained on both sides.
module idct_transpose_buffer
    import idct_pkg::*;
#(
    parameter int unsigned W = IDCT_W,
    parameter int unsigned N = IDCT_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*W-1:0]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*W-1:0]   out_data,
    output logic [2:0]       out_col,
    output logic             out_last
);

    logic [1:0]     full_q, full_d;
    logic           wr_bank_q, wr_bank_d;
    logic [2:0]     wr_row_q, wr_row_d;
    logic           rd_bank_q, rd_bank_d;
    logic [2:0]     rd_col_q, rd_col_d;

    logic           wr_en;
    logic           rd_en;
    logic [1:0]     bank_we;
    logic [N*W-1:0] wr_data;
    logic [N*W-1:0] bank_rdata [2];

    always_comb begin
        in_ready  = ~full_q[wr_bank_q];
        out_valid = full_q[rd_bank_q];
        wr_en     = in_valid & in_ready;
        rd_en     = out_valid & out_ready;
        bank_we   = 2'b00;
        if (wr_en) begin
            bank_we = wr_bank_q ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        wr_data = '0;
        for (int k = 0; k < N; k++) begin
            wr_data[k*W +: W] = sm_norm(in_data[k*W +: W]);
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        idct_tb_bank u_bank (
            .clk   (clk),
            .we    (bank_we[b]),
            .row   (wr_row_q),
            .wdata (wr_data),
            .col   (rd_col_q),
            .rdata (bank_rdata[b])
        );
    end

    // A bank can only be written when empty and read when full, so when both sides finish a
    // block in the same cycle they touch different full bits and both updates must land.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        wr_row_d  = wr_row_q;
        rd_bank_d = rd_bank_q;
        rd_col_d  = rd_col_q;
        if (wr_en) begin
            wr_row_d = wr_row_q + 3'd1;
            if (wr_row_q == IDCT_LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        if (rd_en) begin
            rd_col_d = rd_col_q + 3'd1;
            if (rd_col_q == IDCT_LAST) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            wr_row_q  <= 3'd0;
            rd_bank_q <= 1'b0;
            rd_col_q  <= 3'd0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            wr_row_q  <= wr_row_d;
            rd_bank_q <= rd_bank_d;
            rd_col_q  <= rd_col_d;
        end
    end

    // Gate the data so an empty buffer never exposes stale storage.
    always_comb begin
        out_col  = rd_col_q;
        out_last = out_valid & (rd_col_q == IDCT_LAST);
        out_data = out_valid ? bank_rdata[rd_bank_q] : '0;
    end

endmodule
